key_debounce_multi: RTL



---
 rtl/key_debounce_multi.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner.
// Each channel: 2-FF synchroniser, consecutive-sample debounce, debounced level,
// press/release strobes, long-press detection and optional auto-repeat.
// All outputs are registered and synchronous to clk.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned LONG_CYC     = 100000000,
    parameter int unsigned REPEAT_CYC   = 20000000,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    // Debounce counter never exceeds DEBOUNCE_CYC-1.
    localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYC - 1);

    // Hold counter covers the larger of the long and repeat terminal values.
    localparam int unsigned HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int unsigned HW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;
    localparam logic [HW-1:0] LONG_TERM   = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REPEAT_TERM = (REPEAT_CYC > 0) ? HW'(REPEAT_CYC - 1) : '0;
    localparam bit REPEAT_EN = (REPEAT_CYC > 0);

    // Pin level of a released key; synchroniser resets to it so reset release
    // with idle keys produces no press.
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StLong
    } hold_st_e;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch

        logic          s1_q, s2_q;
        logic          sync;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic          level_q, level_d;
        logic          press_ev, release_ev;
        logic          press_q, release_q;
        hold_st_e      state_q, state_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          long_q, long_d;
        logic          repeat_q, repeat_d;

        // Two-stage synchroniser for the asynchronous pin.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q <= IDLE_PIN;
                s2_q <= IDLE_PIN;
            end else begin
                s1_q <= key_in[i];
                s2_q <= s1_q;
            end
        end

        // Normalise polarity: 1 = pressed.
        assign sync = s2_q ^ IDLE_PIN;

        // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples.
        always_comb begin
            dcnt_d     = dcnt_q;
            level_d    = level_q;
            press_ev   = 1'b0;
            release_ev = 1'b0;
            if (sync == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q >= DEB_TERM) begin
                level_d    = sync;
                dcnt_d     = '0;
                press_ev   = sync;
                release_ev = ~sync;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        // Hold FSM state register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= StIdle;
            end else begin
                state_q <= state_d;
            end
        end

        // Hold FSM next-state logic; release always wins and returns to idle.
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                StIdle: begin
                    if (press_ev) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (release_ev) begin
                        state_d = StIdle;
                    end else if (hcnt_q >= LONG_TERM) begin
                        state_d = StLong;
                    end
                end
                StLong: begin
                    if (release_ev) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Hold FSM outputs: hold counter and long/repeat pulses.
        always_comb begin
            hcnt_d   = hcnt_q;
            long_d   = 1'b0;
            repeat_d = 1'b0;
            if (!level_q || press_ev || release_ev) begin
                // Released, or a press/release edge this cycle: no pulse may coincide.
                hcnt_d = '0;
            end else begin
                unique case (state_q)
                    StHold: begin
                        if (hcnt_q >= LONG_TERM) begin
                            long_d = 1'b1;
                            hcnt_d = '0;
                        end else begin
                            hcnt_d = hcnt_q + HW'(1);
                        end
                    end
                    StLong: begin
                        // With repeat disabled the counter stays frozen.
                        if (REPEAT_EN) begin
                            if (hcnt_q >= REPEAT_TERM) begin
                                repeat_d = 1'b1;
                                hcnt_d   = '0;
                            end else begin
                                hcnt_d = hcnt_q + HW'(1);
                            end
                        end
                    end
                    default: hcnt_d = '0;
                endcase
            end
        end

        // Datapath and registered output strobes.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hcnt_q    <= '0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                dcnt_q    <= dcnt_d;
                level_q   <= level_d;
                press_q   <= press_ev;
                release_q <= release_ev;
                hcnt_q    <= hcnt_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = repeat_q;
    end

endmodule
